// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the FSM state encodings, the default DMEM timeout and the stage-control bundle.
package pipeline_stall_ctrl_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_LOAD_BUBBLE = 2'd1,
        ST_DMEM_WAIT   = 2'd2,
        ST_ERROR       = 2'd3
    } state_t;

    // One bit per stage-register control; stalls hold, flushes/bubbles load a NOP.
    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic idex_stall;
        logic exmem_stall;
        logic memwb_stall;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_bubble;
        logic memwb_bubble;
    } stage_ctrl_t;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Used to accumulate front-end stall cycles for performance statistics.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central hazard controller for a 5-stage pipeline: turns load-use, branch, IMEM and DMEM
// conditions into same-cycle stall/flush/bubble controls, with a sticky DMEM timeout error.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_ex_hazard,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             stat_clear,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_stall,
    output logic             memwb_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic             memwb_bubble,
    output logic             bus_error,
    output logic [CNT_W-1:0] stall_cycles,
    output state_t           fsm_state
);

    localparam int WAIT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W:0] WAIT_ONE = (WAIT_W + 1)'(1);
    localparam logic [WAIT_W:0] WAIT_LIM = (WAIT_W + 1)'(TIMEOUT_CYCLES);

    state_t              state, state_next;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_next;
    logic [WAIT_W:0]     wait_inc;
    logic                err_next;
    logic                hz_armed, hz_armed_next;
    logic                dmem_wait, hazard_eff;
    stage_ctrl_t         ctl;

    // DMEM handshake: dmem_req stays high until the cycle dmem_ready is seen; that cycle completes the access.
    always_comb begin
        ctl           = '0;
        state_next    = state;
        wait_cnt_next = '0;
        err_next      = bus_error;
        hz_armed_next = hz_armed | ~mem_ex_hazard;
        dmem_wait     = dmem_req && !dmem_ready;
        // A hazard held high past its bubble is the same stale pair; re-arm only after it drops.
        hazard_eff    = mem_ex_hazard && hz_armed && (state != ST_LOAD_BUBBLE);
        wait_inc      = (state == ST_DMEM_WAIT) ? ({1'b0, wait_cnt} + WAIT_ONE) : WAIT_ONE;

        if (state == ST_ERROR) begin
            ctl.pc_stall    = 1'b1;
            ctl.ifid_stall  = 1'b1;
            ctl.idex_stall  = 1'b1;
            ctl.exmem_stall = 1'b1;
            ctl.memwb_stall = 1'b1;
        end else if (dmem_wait) begin
            ctl.pc_stall     = 1'b1;
            ctl.ifid_stall   = 1'b1;
            ctl.idex_stall   = 1'b1;
            ctl.exmem_stall  = 1'b1;
            ctl.memwb_bubble = 1'b1;
            if (wait_inc >= WAIT_LIM) begin
                state_next = ST_ERROR;
                err_next   = 1'b1;
            end else begin
                state_next    = ST_DMEM_WAIT;
                wait_cnt_next = wait_inc[WAIT_W-1:0];
            end
        end else if (hazard_eff) begin
            // Branch operand depends on the load, so any coincident redirect is dropped here.
            ctl.pc_stall     = 1'b1;
            ctl.ifid_stall   = 1'b1;
            ctl.idex_stall   = 1'b1;
            ctl.exmem_bubble = 1'b1;
            state_next       = ST_LOAD_BUBBLE;
            hz_armed_next    = 1'b0;
        end else begin
            state_next = ST_RUN;
            if (branch_taken) begin
                ctl.ifid_flush = 1'b1;
                ctl.idex_flush = 1'b1;
            end else if (!imem_ready) begin
                ctl.pc_stall   = 1'b1;
                ctl.ifid_flush = 1'b1;
            end
        end

        if (rst) begin
            ctl = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            bus_error <= 1'b0;
            hz_armed  <= 1'b1;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            bus_error <= err_next;
            hz_armed  <= hz_armed_next;
        end
    end

    assign pc_stall     = ctl.pc_stall;
    assign ifid_stall   = ctl.ifid_stall;
    assign idex_stall   = ctl.idex_stall;
    assign exmem_stall  = ctl.exmem_stall;
    assign memwb_stall  = ctl.memwb_stall;
    assign ifid_flush   = ctl.ifid_flush;
    assign idex_flush   = ctl.idex_flush;
    assign exmem_bubble = ctl.exmem_bubble;
    assign memwb_bubble = ctl.memwb_bubble;
    assign fsm_state    = state;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctl.pc_stall),
        .clr   (stat_clear),
        .count (stall_cycles)
    );

endmodule
